// File: rtl/seq_control_pkg.sv
// seq_control_pkg
//   Shared constants for the sequence controller: opcodes, ALU operation
//   encodings, FSM state encoding and the field offsets of the special
//   (non-Rn) bits in the reg_sig / tri_sig vectors. The Rn fields occupy
//   bits [NREG-1:0]; special fields sit at NREG + <offset>.
package seq_control_pkg;

    // Opcodes (ins[IW-1:IW-4]); any opcode with bit 3 set is illegal.
    localparam logic [3:0] OPC_LOAD   = 4'b0000;
    localparam logic [3:0] OPC_MOV    = 4'b0001;
    localparam logic [3:0] OPC_ADD    = 4'b0010;
    localparam logic [3:0] OPC_XOR    = 4'b0011;
    localparam logic [3:0] OPC_MIN    = 4'b0100;
    localparam logic [3:0] OPC_LDPC   = 4'b0101;
    localparam logic [3:0] OPC_BRANCH = 4'b0110;
    localparam logic [3:0] OPC_MINALL = 4'b0111;

    // ALU operation select
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_XOR = 2'b01;
    localparam logic [1:0] ALU_MIN = 2'b10;

    // FSM state encoding
    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_LOAD    = 4'd1;
    localparam logic [3:0] ST_MOV     = 4'd2;
    localparam logic [3:0] ST_OP_A    = 4'd3;
    localparam logic [3:0] ST_OP_G    = 4'd4;
    localparam logic [3:0] ST_OP_W    = 4'd5;
    localparam logic [3:0] ST_LDPC    = 4'd6;
    localparam logic [3:0] ST_BR      = 4'd7;
    localparam logic [3:0] ST_MA_INIT = 4'd8;
    localparam logic [3:0] ST_MA_G    = 4'd9;
    localparam logic [3:0] ST_MA_A    = 4'd10;
    localparam logic [3:0] ST_MA_W    = 4'd11;
    localparam logic [3:0] ST_DONE    = 4'd12;

    // reg_sig special fields: bit index = NREG + offset
    localparam int REG_A_OFS  = 0;
    localparam int REG_G_OFS  = 1;
    localparam int REG_PC_OFS = 2;

    // tri_sig special fields: bit index = NREG + offset
    localparam int TRI_G_OFS   = 0;
    localparam int TRI_IMM_OFS = 1;
    localparam int TRI_PC_OFS  = 2;

    // First execute state entered after an instruction is accepted.
    function automatic logic [3:0] first_state(input logic [3:0] opc);
        logic [3:0] st;
        case (opc)
            OPC_LOAD:                   st = ST_LOAD;
            OPC_MOV:                    st = ST_MOV;
            OPC_ADD, OPC_XOR, OPC_MIN:  st = ST_OP_A;
            OPC_LDPC:                   st = ST_LDPC;
            OPC_BRANCH:                 st = ST_BR;
            OPC_MINALL:                 st = ST_MA_INIT;
            default:                    st = ST_DONE;  // illegal opcodes
        endcase
        return st;
    endfunction

endpackage

// File: rtl/seq_control_decode.sv
// seq_decode
//   Pure Moore output decode for the sequence controller: maps the current
//   state, the latched instruction register and the MINALL counter k onto
//   the datapath control signals.
//   Ports:
//     state_i    current FSM state
//     ir_i       latched instruction
//     k_i        MINALL register counter
//     reg_sig_o  load enables  {PC, G, A, Rn}
//     tri_sig_o  bus drivers   {PC, IMM, G, Rn}  (at most one bit set)
//     imm_out_o  imm field of the IR
//     alu_op_o   ALU operation
//     branch_o, pc_enable_o, busy_o, done_o, illegal_o, ins_ready_o
module seq_decode
    import seq_control_pkg::*;
#(
    parameter int NREG = 16,
    parameter int DW   = 16,
    parameter int IW   = 24,
    parameter int RAW  = $clog2(NREG)
) (
    input  logic [3:0]      state_i,
    input  logic [IW-1:0]   ir_i,
    input  logic [RAW-1:0]  k_i,
    output logic [NREG+2:0] reg_sig_o,
    output logic [NREG+2:0] tri_sig_o,
    output logic [DW-1:0]   imm_out_o,
    output logic [1:0]      alu_op_o,
    output logic            branch_o,
    output logic            pc_enable_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            illegal_o,
    output logic            ins_ready_o
);

    localparam logic [NREG-1:0] ONE_R = NREG'(1);

    logic [3:0]     opc;
    logic [RAW-1:0] op1;
    logic [RAW-1:0] op2;

    assign opc       = ir_i[IW-1 -: 4];
    assign op1       = ir_i[IW-5 -: RAW];
    assign op2       = ir_i[IW-5-RAW -: RAW];
    assign imm_out_o = ir_i[DW-1:0];

    assign busy_o      = (state_i != ST_IDLE);
    assign ins_ready_o = ~busy_o;

    always_comb begin
        reg_sig_o   = '0;
        tri_sig_o   = '0;
        alu_op_o    = ALU_ADD;
        branch_o    = 1'b0;
        pc_enable_o = 1'b0;
        done_o      = 1'b0;
        illegal_o   = 1'b0;
        case (state_i)
            ST_LOAD: begin
                tri_sig_o[NREG+TRI_IMM_OFS] = 1'b1;
                reg_sig_o[NREG-1:0]         = ONE_R << op1;
            end
            ST_MOV: begin
                tri_sig_o[NREG-1:0] = ONE_R << op2;
                reg_sig_o[NREG-1:0] = ONE_R << op1;
            end
            ST_OP_A: begin
                tri_sig_o[NREG-1:0]       = ONE_R << op1;
                reg_sig_o[NREG+REG_A_OFS] = 1'b1;
            end
            ST_OP_G: begin
                tri_sig_o[NREG-1:0]       = ONE_R << op2;
                reg_sig_o[NREG+REG_G_OFS] = 1'b1;
                case (opc)
                    OPC_XOR: alu_op_o = ALU_XOR;
                    OPC_MIN: alu_op_o = ALU_MIN;
                    default: alu_op_o = ALU_ADD;
                endcase
            end
            ST_OP_W, ST_MA_W: begin
                tri_sig_o[NREG+TRI_G_OFS] = 1'b1;
                reg_sig_o[NREG-1:0]       = ONE_R << op1;
            end
            ST_LDPC: begin
                tri_sig_o[NREG+TRI_PC_OFS] = 1'b1;
                reg_sig_o[NREG-1:0]        = ONE_R << op1;
            end
            ST_BR: begin
                tri_sig_o[NREG-1:0]        = ONE_R << op1;
                reg_sig_o[NREG+REG_PC_OFS] = 1'b1;
                branch_o                   = 1'b1;
            end
            ST_MA_INIT: begin
                // Running minimum starts from R0.
                tri_sig_o[0]              = 1'b1;
                reg_sig_o[NREG+REG_A_OFS] = 1'b1;
            end
            ST_MA_G: begin
                tri_sig_o[NREG-1:0]       = ONE_R << k_i;
                reg_sig_o[NREG+REG_G_OFS] = 1'b1;
                alu_op_o                  = ALU_MIN;
            end
            ST_MA_A: begin
                tri_sig_o[NREG+TRI_G_OFS] = 1'b1;
                reg_sig_o[NREG+REG_A_OFS] = 1'b1;
            end
            ST_DONE: begin
                done_o      = 1'b1;
                pc_enable_o = 1'b1;
                illegal_o   = opc[3];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/seq_control.sv
// seq_control
//   Multi-cycle instruction sequencer. Accepts one instruction at a time,
//   latches it into IR and steps an FSM that emits register-load and
//   bus-driver enables for an external datapath.
//   Handshake: an instruction transfers on a rising edge where ins_valid
//   and ins_ready are both 1. ins_ready is 1 only in IDLE; ins_valid in any
//   other state is ignored and the offered instruction may be held until
//   the controller returns to IDLE.
//   Ports:
//     clk, reset (async, active-high)
//     ins, ins_valid, ins_ready        instruction handshake
//     reg_sig, tri_sig                 datapath load / drive enables
//     imm_out, alu_op                  immediate and ALU select
//     branch, pc_enable, busy, done, illegal   status
//     dbg_state                        current FSM state (debug)
module seq_control
    import seq_control_pkg::*;
#(
    parameter int NREG = 16,
    parameter int DW   = 16,
    parameter int IW   = 24
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IW-1:0]   ins,
    input  logic            ins_valid,
    output logic            ins_ready,
    output logic [NREG+2:0] reg_sig,
    output logic [NREG+2:0] tri_sig,
    output logic [DW-1:0]   imm_out,
    output logic [1:0]      alu_op,
    output logic            branch,
    output logic            pc_enable,
    output logic            busy,
    output logic            done,
    output logic            illegal,
    output logic [3:0]      dbg_state
);

    localparam int             RAW    = $clog2(NREG);
    localparam logic [RAW-1:0] K_ONE  = RAW'(1);
    localparam logic [RAW-1:0] K_LAST = RAW'(NREG - 1);

    logic [3:0]     state_q, state_d;
    logic [IW-1:0]  ir_q, ir_d;
    logic [RAW-1:0] k_q, k_d;

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        k_d     = k_q;
        case (state_q)
            ST_IDLE: begin
                if (ins_valid) begin
                    ir_d    = ins;
                    state_d = first_state(ins[IW-1 -: 4]);
                end
            end
            ST_LOAD, ST_MOV, ST_LDPC, ST_BR, ST_OP_W, ST_MA_W: state_d = ST_DONE;
            ST_OP_A: state_d = ST_OP_G;
            ST_OP_G: state_d = ST_OP_W;
            ST_MA_INIT: begin
                k_d     = K_ONE;
                state_d = ST_MA_G;
            end
            ST_MA_G: state_d = ST_MA_A;
            ST_MA_A: begin
                // Stop after folding in the last register so k never wraps.
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = ST_MA_W;
                end else begin
                    k_d     = k_q + K_ONE;
                    state_d = ST_MA_G;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            k_q     <= k_d;
        end
    end

    assign dbg_state = state_q;

    seq_decode #(
        .NREG (NREG),
        .DW   (DW),
        .IW   (IW),
        .RAW  (RAW)
    ) u_decode (
        .state_i     (state_q),
        .ir_i        (ir_q),
        .k_i         (k_q),
        .reg_sig_o   (reg_sig),
        .tri_sig_o   (tri_sig),
        .imm_out_o   (imm_out),
        .alu_op_o    (alu_op),
        .branch_o    (branch),
        .pc_enable_o (pc_enable),
        .busy_o      (busy),
        .done_o      (done),
        .illegal_o   (illegal),
        .ins_ready_o (ins_ready)
    );

endmodule

// File: doc/seq_control.md
SEQ_CONTROL -- requirements
Module: seq_control

Interface
REQ-001 Parameter NREG, default 16: general registers R0..R(NREG-1); power of two, >= 2; RAW = clog2(NREG).
REQ-002 Parameter DW, default 16: immediate/data width.
REQ-003 Parameter IW, default 24: instruction width; IW >= 4+2*RAW and IW >= 4+RAW+DW.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 ins  input  IW  instruction: opcode ins[IW-1:IW-4], op1 ins[IW-5 -: RAW], op2 ins[IW-5-RAW -: RAW], imm ins[DW-1:0].
REQ-007 ins_valid  input  1  instruction offered.
REQ-008 ins_ready  output  1  controller can accept an instruction.
REQ-009 reg_sig  output  NREG+3  load enables: [NREG-1:0] Rn, [NREG] A, [NREG+1] G, [NREG+2] PC.
REQ-010 tri_sig  output  NREG+3  bus drivers: [NREG-1:0] Rn, [NREG] G, [NREG+1] IMM, [NREG+2] PC.
REQ-011 imm_out  output  DW  latched imm field.
REQ-012 alu_op  output  2  00 ADD, 01 XOR, 10 MIN.
REQ-013 branch, pc_enable, busy, done, illegal  output  1 each.

Function
REQ-014 On ins_valid & ins_ready, ins is latched into IR; all decoding uses IR only.
REQ-015 States: IDLE, LOAD, MOV, OP_A, OP_G, OP_W, LDPC, BR, MA_INIT, MA_G, MA_A, MA_W, DONE; state register updates each clk.
REQ-016 IDLE: ins_ready=1, busy=0; on handshake go to the opcode's first state; otherwise stay.
REQ-017 Opcodes: 0000 LOAD, 0001 MOV, 0010 ADD, 0011 XOR, 0100 MIN, 0101 LDPC, 0110 BRANCH, 0111 MINALL.
REQ-018 LOAD: tri IMM, load R[op1] -> DONE.
REQ-019 MOV: tri R[op2], load R[op1] -> DONE.
REQ-020 ADD/XOR/MIN: OP_A tri R[op1], load A; OP_G tri R[op2], load G, alu_op per opcode; OP_W tri G, load R[op1]; -> DONE.
REQ-021 LDPC: tri PC, load R[op1] -> DONE. BRANCH: BR tri R[op1], load PC, branch=1 -> DONE.
REQ-022 MINALL: MA_INIT tri R0, load A, counter k=1; MA_G tri R[k], load G, alu_op=MIN; MA_A tri G, load A, k=k+1; after MA_A with k=NREG-1 go to MA_W, else MA_G; MA_W tri A... no: tri G, load R[op1]; -> DONE.
REQ-023 MINALL total latency 2*NREG cycles from handshake to DONE (32 at NREG=16).
REQ-024 DONE: one cycle, done=1, pc_enable=1 -> IDLE; back-to-back issue rate one instruction per (execute + 2) cycles.
REQ-025 Opcodes 1000-1111: go directly to DONE with illegal=1 for that DONE cycle; no reg_sig/tri_sig asserted.
REQ-026 At most one tri_sig bit asserted in any cycle; reg_sig/tri_sig zero in IDLE and DONE.
REQ-027 busy=1 in every state except IDLE; ins_ready = ~busy; ins_valid outside IDLE ignored.
REQ-028 Outputs are Moore decode of state, IR and k; counter k is RAW bits, never wraps (bounded by REQ-022).
REQ-029 op1=op2 legal; behaviour unchanged (e.g. ADD R3,R3 doubles R3).

Reset
REQ-030 reset forces IDLE, IR=0, k=0 immediately, including mid-instruction; aborted instruction produces no done.
REQ-031 During and after reset: reg_sig=0, tri_sig=0, imm_out=0, alu_op=00, branch=pc_enable=busy=done=illegal=0, ins_ready=1.

Structure
REQ-032 Shared package holds opcode constants, alu_op encodings, state encoding and bit-index constants for reg_sig/tri_sig fields.
REQ-033 Next-state logic, state/IR/k registers and output decode in one module; one sub-module seq_decode (state+IR+k -> outputs) is natural.

Verification
REQ-034 NREG=16: LOAD R2, imm 0x00AB -> cycle1 tri_sig[17]=1, reg_sig[2]=1, imm_out=0x00AB; cycle2 done=1, pc_enable=1.
REQ-035 ADD R1,R4 -> three cycles: {tri R1,load A},{tri R4,load G,alu_op=00},{tri G,load R1}; then done.
REQ-036 MINALL op1=5 -> done exactly 32 cycles after handshake; MA_G visits R1..R15 in order; final cycle load R5.
REQ-037 BRANCH R7 -> tri_sig[7]=1, reg_sig[18]=1, branch=1 for one cycle; opcode 1010 -> illegal=1 with done, no enables.
REQ-038 reset asserted mid-MINALL (k=6) -> same-instant IDLE, all outputs zero, ins_ready=1, no done.
REQ-039 ins_valid held high during ADD -> second instruction accepted only in IDLE after DONE.
